ysyx_24120009_lsu_ctrl: RTL
===========================

# ysyx_24120009_lsu_ctrl

Load/store controller between the execute stage and the data-memory bus. Takes one memory request per handshake, derives the word-aligned bus address, byte strobes and shifted store data, and runs a single AXI4-Lite-style transaction. Returns the load result, extracted and sign- or zero-extended, to write-back. Misaligned requests are rejected with an error and never reach the bus.

## Interface
- `DATA_WIDTH`, 32 (from shared defs): data and address width; only 32 is supported.
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid` / `in_ready`  in / out  1 / 1  request handshake from EXU.
- `in_is_store`  in  1  1 = store, 0 = load.
- `in_ctrl`  in  3  funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu. Other codes are illegal.
- `in_addr`, `in_wdata`  in  32 each  byte address; store data, right-justified.
- `araddr` out 32, `arvalid` out 1, `arready` in 1  read address channel.
- `rdata` in 32, `rresp` in 2, `rvalid` in 1, `rready` out 1  read data channel.
- `awaddr` out 32, `awvalid` out 1, `awready` in 1  write address channel.
- `wdata` out 32, `wstrb` out 4, `wvalid` out 1, `wready` in 1  write data channel.
- `bresp` in 2, `bvalid` in 1, `bready` out 1  write response channel.
- `out_valid` / `out_ready`  out / in  1 / 1  response handshake to WBU.
- `out_rdata`  out  32  extended load data; 0 for stores.
- `out_err`  out  1  misaligned address, illegal ctrl, or nonzero resp.

## Operation
- FSM states: IDLE, RADDR, RDATA, WREQ, WRESP, DONE.
- IDLE: `in_ready`=1. On `in_valid`, latch the request. Misaligned or illegal → DONE with err=1. Load → RADDR. Store → WREQ.
- Misaligned means h/hu with addr[0]=1, or w with addr[1:0]≠0. Store with ctrl 100/101 is illegal.
- Bus address = addr & ~3 on both araddr and awaddr.
- wstrb: b = 0001<<addr[1:0]; h = 0011<<addr[1:0]; w = 1111.
- wdata = in_wdata << (8·addr[1:0]).
- RADDR: `arvalid`=1 until `arready`, then RDATA.
- RDATA: `rready`=1. On `rvalid`, shift rdata right by 8·addr[1:0]. Select byte/halfword/word. Sign-extend for b/h, zero-extend for bu/hu. Capture err = (rresp≠0). Go to DONE.
- WREQ: `awvalid` and `wvalid` assert together. Each drops independently after its own handshake. Once both handshakes are done (same or different cycles) → WRESP.
- WRESP: `bready`=1. On `bvalid`, capture err = (bresp≠0) → DONE.
- DONE: `out_valid`=1; `out_rdata`/`out_err` held stable. On `out_ready` → IDLE.
- Only one transaction is ever outstanding. No pipelining.

## Timing
- Reset: state IDLE. All bus valid/ready outputs 0, `out_valid`=0, `out_rdata`=0, `out_err`=0, `in_ready`=1 (IDLE).
- Async reset mid-transaction drops every valid immediately and discards the request; no response is produced.
- All outputs are registered or decoded from state only. No combinational path from any input to any output.
- Load, zero-wait slave: accept at cycle 0. `arvalid` cycles 1. `rready` cycle 2 with rvalid. `out_valid` cycle 3.
- Store, zero-wait slave: aw/w in cycle 1, b in cycle 2, `out_valid` cycle 3.
- Error path: accept at cycle 0, `out_valid` at cycle 1, zero bus activity.
- `in_ready` is 0 in every state except IDLE. The DONE→IDLE transition takes one cycle; back-to-back requests are spaced ≥1 idle-ready cycle.
- Bus valids stay asserted and payload stays stable until the handshake; they never retract.

## Structure
- Shared package/defs header holds: `ysyx_24120009_DATA_WIDTH`, funct3 load/store codes, FSM state encodings, and the AXI resp OKAY constant.
- One natural sub-module, `ysyx_24120009_load_extend`: combinational rdata shift, byte/halfword/word select and sign/zero extension. It is reused by any future cache refill path.

## Test plan
- lw addr 0x80000004, rdata 0xDEADBEEF, zero-wait → araddr 0x80000004, `out_valid` at cycle 3, out_rdata 0xDEADBEEF, err 0.
- lb addr 0x80000003, rdata 0x80112233 → araddr 0x80000000, out_rdata 0xFFFFFF80. Same with lbu → 0x00000080.
- sh addr 0x80000002, wdata 0x0000ABCD → wstrb 1100, wdata 0xABCD0000, awaddr 0x80000000. awready delayed 3 cycles while wready is immediate; response waits for both handshakes plus B.
- lw addr 0x80000002 → out_err=1 at cycle 1, arvalid/awvalid never asserted. sbu (ctrl 100 store) gives the same response.
- rresp=2'b10 on lh addr 0x10 → out_err=1. Hold `out_ready`=0 for 5 cycles → out_valid, rdata and err stay stable.
- reset pulse while in RDATA → arvalid/rready/out_valid go 0 in the same cycle, in_ready=1. The next lw completes normally.

Source files
------------

// File: rtl/ysyx_24120009_lsu_ctrl_pkg.sv
// Shared definitions for the load/store controller: data width, funct3
// load/store codes, FSM state encoding, AXI response codes and the small
// request-decode helpers used when a request is accepted.
package ysyx_24120009_lsu_ctrl_pkg;

    localparam int ysyx_24120009_DATA_WIDTH = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RADDR,
        S_RDATA,
        S_WREQ,
        S_WRESP,
        S_DONE
    } lsu_state_e;

    // 1 when the request must be answered with an error and kept off the bus:
    // misaligned halfword/word, unsigned store, or an unknown funct3.
    function automatic logic lsu_req_bad(input logic is_store, input logic [2:0] ctrl,
                                         input logic [1:0] off);
        logic bad;
        case (ctrl)
            F3_B:    bad = 1'b0;
            F3_H:    bad = off[0];
            F3_W:    bad = (off != 2'b00);
            F3_BU:   bad = is_store;
            F3_HU:   bad = is_store | off[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Byte lanes touched by a store; ctrl[1:0] gives the access size.
    function automatic logic [3:0] lsu_wstrb(input logic [2:0] ctrl, input logic [1:0] off);
        logic [3:0] strb;
        case (ctrl[1:0])
            2'b00:   strb = 4'b0001 << off;
            2'b01:   strb = 4'b0011 << off;
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/ysyx_24120009_lsu_ctrl_load_extend.sv
// Load data extraction: shifts the bus word right by the byte offset, selects
// byte/halfword/word and sign- or zero-extends according to funct3.
// Purely combinational so it can also serve a cache refill path.
//   rdata_i  raw bus read word
//   off_i    byte offset of the access within the word
//   ctrl_i   load funct3
//   data_o   extended result
module ysyx_24120009_load_extend
    import ysyx_24120009_lsu_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = ysyx_24120009_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] rdata_i,
    input  logic [1:0]            off_i,
    input  logic [2:0]            ctrl_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic [DATA_WIDTH-1:0] shifted;

    assign shifted = rdata_i >> {off_i, 3'b000};

    always_comb begin
        data_o = shifted;
        case (ctrl_i)
            F3_B:    data_o = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
            F3_BU:   data_o = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
            F3_H:    data_o = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
            F3_HU:   data_o = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
            default: data_o = shifted;
        endcase
    end

endmodule

// File: rtl/ysyx_24120009_lsu_ctrl.sv
// Load/store controller between EXU and an AXI4-Lite-style data bus.
// Accepts one request, runs one bus transaction (or rejects a bad request
// without touching the bus) and returns the extended load data / error.
//   clock, reset                   clock, async active-high reset
//   in_*                           request from EXU (valid/ready handshake)
//   ar*/r*                         read address / read data channels
//   aw*/w*/b*                      write address / data / response channels
//   out_valid/out_ready, out_rdata, out_err   response to WBU
// Every output is a register or a decode of registered state only.
module ysyx_24120009_lsu_ctrl
    import ysyx_24120009_lsu_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = ysyx_24120009_DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_is_store,
    input  logic [2:0]            in_ctrl,
    input  logic [DATA_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0] in_wdata,
    output logic [DATA_WIDTH-1:0] araddr,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready,
    output logic [DATA_WIDTH-1:0] awaddr,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [3:0]            wstrb,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_rdata,
    output logic                  out_err
);

    lsu_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] addr_q;
    logic [1:0]            off_q;
    logic [2:0]            ctrl_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [3:0]            wstrb_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;
    logic                  aw_done_q;
    logic                  w_done_q;

    logic                  req_bad;
    logic [DATA_WIDTH-1:0] load_ext;

    assign req_bad = lsu_req_bad(in_is_store, in_ctrl, in_addr[1:0]);

    ysyx_24120009_load_extend #(.DATA_WIDTH(DATA_WIDTH)) u_load_extend (
        .rdata_i (rdata),
        .off_i   (off_q),
        .ctrl_i  (ctrl_q),
        .data_o  (load_ext)
    );

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (req_bad)          state_d = S_DONE;
                    else if (in_is_store) state_d = S_WREQ;
                    else                  state_d = S_RADDR;
                end
            end
            S_RADDR: if (arready) state_d = S_RDATA;
            S_RDATA: if (rvalid)  state_d = S_DONE;
            // AW and W may complete in either order; leave only once both have.
            S_WREQ:  if ((aw_done_q | awready) && (w_done_q | wready)) state_d = S_WRESP;
            S_WRESP: if (bvalid)    state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state and registered payload
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        arvalid   = (state_q == S_RADDR);
        rready    = (state_q == S_RDATA);
        awvalid   = (state_q == S_WREQ) && !aw_done_q;
        wvalid    = (state_q == S_WREQ) && !w_done_q;
        bready    = (state_q == S_WRESP);
        out_valid = (state_q == S_DONE);
        araddr    = addr_q;
        awaddr    = addr_q;
        wdata     = wdata_q;
        wstrb     = wstrb_q;
        out_rdata = rdata_q;
        out_err   = err_q;
    end

    // Request latch and result capture
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q    <= '0;
            off_q     <= '0;
            ctrl_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (in_valid) begin
                    addr_q    <= {in_addr[DATA_WIDTH-1:2], 2'b00};
                    off_q     <= in_addr[1:0];
                    ctrl_q    <= in_ctrl;
                    wdata_q   <= in_wdata << {in_addr[1:0], 3'b000};
                    wstrb_q   <= lsu_wstrb(in_ctrl, in_addr[1:0]);
                    rdata_q   <= '0;      // stores and rejected requests return 0
                    err_q     <= req_bad;
                    aw_done_q <= 1'b0;
                    w_done_q  <= 1'b0;
                end
                S_RDATA: if (rvalid) begin
                    rdata_q <= load_ext;
                    err_q   <= (rresp != RESP_OKAY);
                end
                S_WREQ: begin
                    if (awvalid && awready) aw_done_q <= 1'b1;
                    if (wvalid && wready)   w_done_q  <= 1'b1;
                end
                S_WRESP: if (bvalid) err_q <= (bresp != RESP_OKAY);
                default: ;
            endcase
        end
    end

endmodule
